// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler feeding the 32-point FFT core: collects N complex
// samples from a valid/ready stream into one of two banks and presents full banks in order.
module fft_frame_loader #(
    parameter int N        = 32,
    parameter int SAMPLE_W = 64,
    parameter int BITREV   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SAMPLE_W-1:0]   s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [N*SAMPLE_W-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

    bank_state_t         state [2];
    bank_state_t         state_next [2];
    logic                wr_bank;
    logic                rd_bank;
    logic                last_bank;
    logic                shown;
    logic                disp_bank;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    slot;
    logic [SAMPLE_W-1:0] mem [2][N];
    logic                accept;
    logic                at_end;
    logic                commit;
    logic                drop;
    logic                consume;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

    assign slot        = (BITREV != 0) ? bitrev(wr_idx) : wr_idx;
    assign s_ready     = (state[wr_bank] != FULL);
    assign frame_valid = (state[rd_bank] == FULL);
    assign accept      = s_valid && s_ready;
    assign at_end      = (wr_idx == IDX_W'(N - 1));
    assign commit      = accept && at_end;
    assign drop        = accept && s_last && !at_end;
    assign consume     = frame_valid && frame_ready;

    // When nothing is full, keep showing the bank last presented; zero until one has been.
    assign disp_bank = frame_valid ? rd_bank : last_bank;

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign frame_data[k*SAMPLE_W +: SAMPLE_W] =
            (frame_valid || shown) ? mem[disp_bank][k] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
        end else begin
            state[0] <= state_next[0];
            state[1] <= state_next[1];
        end
    end

    always_comb begin
        state_next[0] = state[0];
        state_next[1] = state[1];
        if (accept) begin
            if (commit) begin
                state_next[wr_bank] = FULL;
            end else if (drop) begin
                state_next[wr_bank] = EMPTY;
            end else begin
                state_next[wr_bank] = FILLING;
            end
        end
        if (consume) begin
            state_next[rd_bank] = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            last_bank <= 1'b0;
            shown     <= 1'b0;
            wr_idx    <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    mem[b][k] <= '0;
                end
            end
        end else begin
            frame_err <= (commit && !s_last) || drop;
            if (accept) begin
                mem[wr_bank][slot] <= s_data;
                wr_idx <= (commit || drop) ? '0 : wr_idx + 1'b1;
            end
            if (commit) begin
                wr_bank   <= ~wr_bank;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (frame_valid) begin
                last_bank <= rd_bank;
                shown     <= 1'b1;
            end
            if (consume) begin
                rd_bank <= ~rd_bank;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: natural-order and bit-reversed instances share one stream
// and are checked every cycle against a queue-based frame model.
module tb_fft_frame_loader;
    localparam int N   = 32;
    localparam int SW  = 64;
    localparam int LOG = 5;

    typedef logic [N*SW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [SW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          frame_ready = 1'b0;

    logic          s_ready0, frame_valid0, frame_err0;
    logic [15:0]   frame_cnt0;
    frame_t        frame_data0;
    logic          s_ready1, frame_valid1, frame_err1;
    logic [15:0]   frame_cnt1;
    frame_t        frame_data1;

    fft_frame_loader #(.N(N), .SAMPLE_W(SW), .BITREV(0)) dut0 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready0), .frame_data(frame_data0), .frame_valid(frame_valid0),
        .frame_ready(frame_ready), .frame_err(frame_err0), .frame_cnt(frame_cnt0)
    );

    fft_frame_loader #(.N(N), .SAMPLE_W(SW), .BITREV(1)) dut1 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready1), .frame_data(frame_data1), .frame_valid(frame_valid1),
        .frame_ready(frame_ready), .frame_err(frame_err1), .frame_cnt(frame_cnt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: presented-frame queues, last presented frames, partial beats.
    frame_t        q0[$];
    frame_t        q1[$];
    frame_t        last0 = '0;
    frame_t        last1 = '0;
    logic [SW-1:0] part[$];
    logic [15:0]   m_cnt = '0;
    logic          m_err = 1'b0;
    bit            acc_last = 1'b0;
    bit            rand_rdy = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LOG; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    function automatic logic [63:0] slot_of(input frame_t f, input int k);
        return f[k*SW +: SW];
    endfunction

    task automatic model_edge();
        bit acc, rel;
        frame_t f0, f1;
        if (reset) begin
            q0.delete(); q1.delete(); part.delete();
            last0 = '0; last1 = '0; m_cnt = '0; m_err = 1'b0; acc_last = 1'b0;
            return;
        end
        acc = s_valid && (q0.size() < 2);
        rel = (q0.size() > 0) && frame_ready;
        acc_last = acc;
        m_err = 1'b0;
        if (rel) begin
            last0 = q0.pop_front();
            last1 = q1.pop_front();
        end
        if (acc) begin
            part.push_back(s_data);
            if (part.size() == N) begin
                f0 = '0; f1 = '0;
                for (int n = 0; n < N; n++) begin
                    f0[n*SW +: SW] = part[n];
                    f1[brev(n)*SW +: SW] = part[n];
                end
                q0.push_back(f0);
                q1.push_back(f1);
                m_cnt = m_cnt + 16'd1;
                m_err = !s_last;
                part.delete();
            end else if (s_last) begin
                part.delete();
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compare();
        frame_t e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : last0;
        e1 = (q1.size() > 0) ? q1[0] : last1;
        check_eq("s_ready0", 64'(s_ready0), 64'(q0.size() < 2));
        check_eq("s_ready1", 64'(s_ready1), 64'(q0.size() < 2));
        check_eq("frame_valid0", 64'(frame_valid0), 64'(q0.size() > 0));
        check_eq("frame_valid1", 64'(frame_valid1), 64'(q0.size() > 0));
        check_eq("frame_err0", 64'(frame_err0), 64'(m_err));
        check_eq("frame_err1", 64'(frame_err1), 64'(m_err));
        check_eq("frame_cnt0", 64'(frame_cnt0), 64'(m_cnt));
        check_eq("frame_cnt1", 64'(frame_cnt1), 64'(m_cnt));
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("d0_slot%0d", k), slot_of(frame_data0, k), slot_of(e0, k));
            check_eq($sformatf("d1_slot%0d", k), slot_of(frame_data1, k), slot_of(e1, k));
        end
    endtask

    task automatic step();
        if (rand_rdy) frame_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_edge();
        compare();
    endtask

    task automatic send_beat(input logic [63:0] d, input bit last, input bit gaps);
        int n = 0;
        s_data = d; s_last = last; s_valid = 1'b1;
        acc_last = 1'b0;
        while (!acc_last && n < 400) begin
            step();
            n++;
        end
        check_eq("beat_accepted", 64'(acc_last), 64'd1);
        s_valid = 1'b0; s_last = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic send_frame(input int nbeats, input int last_at, input bit rnd, input bit gaps);
        for (int n = 0; n < nbeats; n++) begin
            logic [63:0] d;
            d = rnd ? {$urandom, $urandom} : {32'(n), ~32'(n)};
            send_beat(d, n == last_at, gaps);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [15:0] cnt_before;

        reset = 1'b1;
        repeat (2) step();
        check_eq("rst_ready", 64'(s_ready0), 64'd1);
        check_eq("rst_valid", 64'(frame_valid0), 64'd0);
        check_eq("rst_cnt", 64'(frame_cnt0), 64'd0);
        check_eq("rst_data", slot_of(frame_data0, 0), 64'd0);
        reset = 1'b0;

        // Directed ramp frame, consumer always ready
        frame_ready = 1'b1;
        send_frame(31, -1, 1'b0, 1'b0);
        send_beat({32'd31, ~32'd31}, 1'b1, 1'b0);
        check_eq("t1_valid", 64'(frame_valid0), 64'd1);
        check_eq("t1_slot5", slot_of(frame_data0, 5), {32'h5, 32'hFFFFFFFA});
        check_eq("t1_cnt", 64'(frame_cnt0), 64'd1);
        check_eq("t1_err", 64'(frame_err0), 64'd0);
        check_eq("t2_slot1", slot_of(frame_data1, 1), {32'd16, ~32'd16});
        check_eq("t2_slot3", slot_of(frame_data1, 3), {32'd24, ~32'd24});
        check_eq("t2_slot31", slot_of(frame_data1, 31), {32'd31, ~32'd31});
        step();
        check_eq("t1_valid_one_cycle", 64'(frame_valid0), 64'd0);

        // Backpressure: two frames held, third stalls
        frame_ready = 1'b0;
        send_frame(32, 31, 1'b1, 1'b0);
        send_frame(32, 31, 1'b1, 1'b0);
        d = {$urandom, $urandom};
        s_data = d; s_valid = 1'b1; s_last = 1'b0;
        repeat (3) begin
            step();
            check_eq("t3_stall", 64'(s_ready0), 64'd0);
        end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check_eq("t3_ready_back", 64'(s_ready0), 64'd1);
        send_beat(d, 1'b0, 1'b0);
        send_frame(31, 30, 1'b1, 1'b0);
        frame_ready = 1'b1;
        repeat (3) step();

        // Early s_last drops the partial frame
        cnt_before = m_cnt;
        send_frame(10, 9, 1'b1, 1'b0);
        check_eq("t4_err", 64'(frame_err0), 64'd1);
        d = {$urandom, $urandom};
        send_beat(d, 1'b0, 1'b0);
        check_eq("t4_err_once", 64'(frame_err0), 64'd0);
        send_frame(30, -1, 1'b1, 1'b0);
        send_beat({$urandom, $urandom}, 1'b1, 1'b0);
        check_eq("t4_cnt", 64'(frame_cnt0), 64'(cnt_before + 16'd1));
        check_eq("t4_slot0", slot_of(frame_data0, 0), d);

        // Missing s_last still commits, with an error pulse
        send_frame(32, -1, 1'b1, 1'b0);
        check_eq("t5_err", 64'(frame_err0), 64'd1);
        check_eq("t5_valid", 64'(frame_valid0), 64'd1);
        step();
        check_eq("t5_err_pulse", 64'(frame_err0), 64'd0);

        // Reset mid-frame with a full frame pending
        frame_ready = 1'b0;
        send_frame(32, 31, 1'b1, 1'b0);
        send_frame(21, -1, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_valid", 64'(frame_valid0), 64'd0);
        check_eq("t6_ready", 64'(s_ready0), 64'd1);
        check_eq("t6_cnt", 64'(frame_cnt0), 64'd0);
        check_eq("t6_slot0", slot_of(frame_data0, 0), 64'd0);
        check_eq("t6_slot31", slot_of(frame_data0, 31), 64'd0);
        frame_ready = 1'b1;
        d = {$urandom, $urandom};
        send_beat(d, 1'b0, 1'b0);
        send_frame(31, 30, 1'b1, 1'b0);
        check_eq("t6_reload_slot0", slot_of(frame_data0, 0), d);

        // Random traffic with random consumer readiness and occasional framing errors
        rand_rdy = 1'b1;
        for (int f = 0; f < 14; f++) begin
            int lp;
            if ($urandom_range(0, 5) == 0) lp = int'($urandom_range(0, N - 1));
            else if ($urandom_range(0, 5) == 0) lp = -1;
            else lp = N - 1;
            send_frame(N, lp, 1'b1, 1'b1);
        end
        rand_rdy = 1'b0;
        frame_ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream feeder for the 32-point butterfly FFT core.
- Accepts one complex sample per cycle over a valid/ready stream and assembles N samples into a full frame.
- Presents the frame as the flat N*64-bit bus that drives the core's inpmac input.
- Double-buffered (ping-pong), so frame k+1 can fill while frame k is held stable for the core.

Parameters:
- N, 32, samples per frame; power of two, ≥ 4.
- SAMPLE_W, 64, complex sample width: [63:32] real, [31:0] imag, both two's complement; the block passes them through opaquely.
- BITREV, 0, 0 = sample n goes to slot n; 1 = sample n goes to slot bitrev(n) over log2(N) bits.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- reset, input, 1, synchronous, active-high.
- s_data, input, SAMPLE_W, incoming complex sample.
- s_valid, input, 1, s_data is valid.
- s_last, input, 1, marks the final sample of a frame.
- s_ready, output, 1, loader can accept a sample this cycle.
- frame_data, output, N*SAMPLE_W, assembled frame; slot k occupies bits [SAMPLE_W*k+SAMPLE_W-1 : SAMPLE_W*k].
- frame_valid, output, 1, frame_data holds a complete frame.
- frame_ready, input, 1, consumer releases the presented frame.
- frame_err, output, 1, one-cycle pulse on a framing error.
- frame_cnt, output, 16, count of frames committed; wraps modulo 2^16.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - Both banks cleared to all-zero; wr_bank = 0, rd_bank = 0, wr_idx = 0.
  - Both bank-full flags cleared.
  - Outputs after reset: s_ready = 1, frame_valid = 0, frame_data = 0, frame_err = 0, frame_cnt = 0.
  - A reset mid-frame discards any partial frame and any full frames.
- Sample accept:
  - A beat is accepted when s_valid && s_ready.
  - On accept, s_data is written to slot wr_idx, or slot bitrev(wr_idx) when BITREV = 1, of bank wr_bank, then wr_idx increments.
  - s_ready = !full[wr_bank]. It is registered-state-derived, with no combinational path from frame_ready.
- Frame commit:
  - Occurs when the accepted beat has wr_idx == N-1.
  - Sets full[wr_bank], toggles wr_bank, clears wr_idx to 0, and increments frame_cnt.
  - frame_valid rises on the cycle after the N-th beat is accepted (latency 1).
  - Commit happens by count regardless of s_last.
- s_last checking:
  - Accepted beat with s_last = 0 at wr_idx == N-1: frame still commits; frame_err pulses the next cycle.
  - Accepted beat with s_last = 1 at wr_idx < N-1: the partial frame is dropped, wr_idx resets to 0, the bank stays not-full, frame_cnt is unchanged, and frame_err pulses the next cycle. The dropped bank's stale slots are overwritten by the next frame.
- Output side:
  - frame_valid = full[rd_bank].
  - frame_data = bank[rd_bank], held stable while frame_valid = 1.
  - When frame_valid = 0, frame_data holds the last presented bank's contents (zero after reset).
  - On frame_valid && frame_ready: clear full[rd_bank] and toggle rd_bank. If the other bank is already full, frame_valid stays high and the next frame appears on the following cycle.
- Backpressure:
  - With both banks full, s_ready = 0 and further samples stall with no loss.
  - Release and commit in the same cycle are both honoured: one bank frees and the other fills.
- Occupancy and ordering:
  - Frames are never reordered.
  - The bank being presented is never written.
  - At most 2 frames are buffered.
- Implementation intent:
  - Two flop banks of N*SAMPLE_W, one-hot slot write enable, 2:1 output mux.
  - State machine per bank: EMPTY -> FILLING -> FULL -> EMPTY.

Test Plan:
1. Reset, then stream samples n = 0..31 with s_data = {n, ~n}, s_last on n = 31, frame_ready = 1 → frame_valid is high for exactly 1 cycle starting 1 cycle after beat 31; slot 5 = {32'h5, 32'hFFFFFFFA}; frame_cnt = 1; frame_err stays 0.
2. BITREV = 1, same stream → slot 1 = sample 16, slot 3 = sample 24, slot 31 = sample 31.
3. Hold frame_ready = 0 and stream 3 frames back-to-back →
   - s_ready drops the cycle after beat 63 (two frames held) and beat 64 stalls.
   - Raise frame_ready for 1 cycle → frame 1 presented, s_ready returns to 1, and frame 3 completes with data intact.
4. Assert s_last on beat 9 of a frame, then send a clean 32-beat frame → frame_err pulses once, frame_cnt increments by 1 only, and the next frame's slot 0 holds the first beat after the error.
5. Send 32 beats with s_last never asserted → frame commits, frame_valid rises, and frame_err pulses once, 1 cycle after beat 31.
6. Assert reset after beat 20 while a full frame is also pending → next cycle: frame_valid = 0, frame_data = 0, s_ready = 1, frame_cnt = 0; a following clean frame loads at slot 0.
